sa_seq_ctrl: RTL and testbench
==============================

Name: sa_seq_ctrl

Overview:
Sequencer for the weight-stationary systolic array built from the PE/PE2 tiles. On a start handshake it loads weights through the horizontal pass chain, then streams a programmable number of input vectors with row skew. It also flags per-column result-valid at the array bottom, then pulses done. It sits between the host/config logic and the SA's shared load_weight, out_model, Sx and Sy control nets.

Parameters:
ROWS, 4, array rows (≥2)
COLS, 4, array columns (≥2)
VEC_W, 8, width of vector count/index
PE_LAT, 1, cycles from PE input to registered out_bot (per row)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  run request; sampled only in IDLE
abort  in  1  synchronous abort of an in-flight run
cfg_num_vec  in  VEC_W  vectors to stream; latched at start
cfg_mode  in  1  1 = 4b×4b, 0 = dual 2b; latched
cfg_sx  in  1  signed X; latched
cfg_sy  in  1  signed Y; latched
cfg_skip_weight  in  1  reuse resident weights (skip LOAD_W); latched
busy  out  1  high in LOAD_W/COMPUTE/DONE
done  out  1  one-cycle pulse at end of run
load_weight  out  1  to all PEs
out_model  out  1  latched cfg_mode
Sx  out  1  latched cfg_sx
Sy  out  1  latched cfg_sy
w_rd_en  out  1  weight buffer read enable
w_rd_addr  out  $clog2(COLS)  column index of weight being driven
x_row_en  out  ROWS  row r presents its input this cycle
x_vec_idx  out  VEC_W  vector index for row 0 (row r uses idx−r)
out_col_valid  out  COLS  bottom of column c holds a valid result

Behaviour:
- Reset: state IDLE. All outputs 0, including latched cfg regs and counters.
- States: IDLE, LOAD_W, COMPUTE, DONE.
- IDLE:
  - start=1 latches cfg.
  - Next state is LOAD_W, or COMPUTE if cfg_skip_weight=1.
  - start while busy is ignored.
- LOAD_W: exactly COLS cycles, counter k=0..COLS-1.
  - load_weight=1, w_rd_en=1, w_rd_addr=COLS-1-k.
  - Farthest column is fed first, so after COLS cycles PE column c holds the weight issued at k=COLS-1-c.
  - Then go to COMPUTE.
- COMPUTE: length L = N + ROWS + COLS - 2 + PE_LAT, with N = latched num_vec and relative cycle t=0..L-1.
  - x_row_en[r]=1 for r ≤ t ≤ r+N-1.
  - x_vec_idx = t while t<N, else 0.
  - out_col_valid[c]=1 for ROWS-1+c+PE_LAT ≤ t ≤ ROWS-2+c+PE_LAT+N.
  - load_weight=0 throughout.
  - After t=L-1 go to DONE.
- N=0: COMPUTE is skipped. LOAD_W (if any) goes straight to DONE, and no x_row_en or out_col_valid is asserted.
- DONE: one cycle. done=1, busy=1, then IDLE.
  - start is ignored in DONE; the first acceptable start is the following IDLE cycle.
- abort:
  - From any non-IDLE state, next cycle goes to IDLE.
  - All strobes drop, and no done pulse.
  - Resident weights are undefined if aborted in LOAD_W. The next run must not use skip_weight; this is not enforced.
- reset dominates abort and start. A mid-run reset behaves like abort and also clears latched cfg.
- out_model, Sx and Sy hold their latched values from start until the next accepted start (not cleared at DONE).
- All outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
Macro SA_SEQ_CTRL_PERF_EN.
- When defined: adds outputs perf_busy_cyc [31:0] (counts cycles with busy=1) and perf_runs [15:0] (counts done pulses).
  - Both saturate at all-ones.
  - Both are cleared by reset only.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package sa_pkg holds:
  - enum sa_state_e {IDLE, LOAD_W, COMPUTE, DONE}
  - localparam helpers for compute length
  - a cfg struct (num_vec, mode, sx, sy, skip_weight)
- One sub-module, sa_valid_skew: a parameterised shift register that turns a single-bit valid into DEPTH staggered copies.
  - One instance generates x_row_en from row 0's enable.
  - One instance generates out_col_valid from the bottom-row column-0 valid.
- The FSM and counters stay in sa_seq_ctrl.

Test Plan:
- ROWS=COLS=4, PE_LAT=1; start at cycle 0 with num_vec=3, mode=1, skip=0:
  - load_weight=1 cycles 1–4, w_rd_addr 3,2,1,0.
  - COMPUTE cycles 5–14: x_row_en[0] at 5–7, x_row_en[3] at 8–10; out_col_valid[0] at 9–11, out_col_valid[3] at 12–14.
  - done at 15, busy=0 at 16.
- Same config with skip=1 → no load_weight; COMPUTE 1–10; done at 11; out_model/Sx/Sy match cfg.
- num_vec=0, skip=0 → LOAD_W 1–4, done at 5; x_row_en and out_col_valid never asserted.
- abort at cycle 7 of the first scenario → cycle 8 IDLE, all strobes 0, no done. A new start at cycle 9 is accepted.
- start held high continuously with num_vec=1, skip=1:
  - Runs are back-to-back with one IDLE cycle between done and the next LOAD_W/COMPUTE.
  - start during busy is never accepted.
- Reset asserted mid-COMPUTE → next cycle all outputs 0, state IDLE. With SA_SEQ_CTRL_PERF_EN, the perf counters are zero.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array sequencer.
// Holds the FSM state encoding, the latched run configuration and
// the compute-phase length arithmetic used by sa_seq_ctrl.
package sa_pkg;

   // Width of the latched vector count (VEC_W of the sequencer must not exceed it)
   localparam int SA_NV_W  = 16;
   // Width of the compute-phase cycle counter
   localparam int SA_CNT_W = 24;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD_W  = 2'd1,
      COMPUTE = 2'd2,
      DONE    = 2'd3
   } sa_state_e;

   typedef struct packed {
      logic [SA_NV_W-1:0] num_vec;
      logic               mode;
      logic               sx;
      logic               sy;
      logic               skip_weight;
   } sa_cfg_t;

   // Compute phase spans the vectors plus the skew fill/drain of rows and columns
   function automatic logic [SA_CNT_W-1:0] sa_compute_len(input logic [SA_NV_W-1:0] num_vec,
                                                          input int rows, input int cols,
                                                          input int pe_lat);
      return SA_CNT_W'(num_vec) + SA_CNT_W'(rows + cols - 32'sd2 + pe_lat);
   endfunction

   // First compute cycle at which the bottom of column 0 holds a result
   function automatic logic [SA_CNT_W-1:0] sa_col0_first(input int rows, input int pe_lat);
      return SA_CNT_W'(rows - 32'sd1 + pe_lat);
   endfunction

endpackage

// File: rtl/sa_valid_skew.sv
// Turns one registered valid bit into DEPTH copies, each delayed one more
// cycle than the previous. Tap 0 is the input itself (already a flop upstream),
// so every output bit is driven by a register.
module sa_valid_skew #(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             valid_in,
   output logic [DEPTH-1:0] valid_out
);

   logic [DEPTH-1:1] stage_r;

   // Shift the valid down the taps; clr empties the pipe so strobes drop at once
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         stage_r <= {(DEPTH-1){1'b0}};
      end else begin
         stage_r[1] <= valid_in;
         for (int i = 2; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign valid_out = {stage_r, valid_in};

endmodule

// File: rtl/sa_seq_ctrl.sv
// Weight-stationary systolic array sequencer: loads weights through the
// horizontal chain, streams skewed input vectors, flags per-column results
// and pulses done. Optional performance counters are built when the macro
// SA_SEQ_CTRL_PERF_EN is defined.
module sa_seq_ctrl
   import sa_pkg::*;
#(
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int VEC_W  = 8,
   parameter int PE_LAT = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic [VEC_W-1:0]         cfg_num_vec,
   input  logic                     cfg_mode,
   input  logic                     cfg_sx,
   input  logic                     cfg_sy,
   input  logic                     cfg_skip_weight,
   output logic                     busy,
   output logic                     done,
   output logic                     load_weight,
   output logic                     out_model,
   output logic                     Sx,
   output logic                     Sy,
   output logic                     w_rd_en,
   output logic [$clog2(COLS)-1:0]  w_rd_addr,
   output logic [ROWS-1:0]          x_row_en,
   output logic [VEC_W-1:0]         x_vec_idx,
   output logic [COLS-1:0]          out_col_valid
`ifdef SA_SEQ_CTRL_PERF_EN
   ,
   output logic [31:0]              perf_busy_cyc,
   output logic [15:0]              perf_runs
`endif
);

   localparam int AW = $clog2(COLS);

   sa_state_e             state_r;
   sa_cfg_t               cfg_r;
   sa_cfg_t               cfg_in_s;
   logic [AW-1:0]         k_r;
   logic [SA_CNT_W-1:0]   t_r;
   logic                  row0_en_r;
   logic                  col0_val_r;
   logic [SA_CNT_W-1:0]   n_s;
   logic [SA_CNT_W-1:0]   len_s;
   logic [SA_CNT_W-1:0]   t_nxt_s;
   logic [SA_CNT_W-1:0]   col_first_s;
   logic                  row0_nxt_s;
   logic                  col0_nxt_s;
   logic                  skew_clr_s;

   // Next-cycle strobe windows for row 0 and the bottom of column 0
   always_comb begin
      cfg_in_s.num_vec     = SA_NV_W'(cfg_num_vec);
      cfg_in_s.mode        = cfg_mode;
      cfg_in_s.sx          = cfg_sx;
      cfg_in_s.sy          = cfg_sy;
      cfg_in_s.skip_weight = cfg_skip_weight;
      n_s         = SA_CNT_W'(cfg_r.num_vec);
      len_s       = sa_compute_len(cfg_r.num_vec, ROWS, COLS, PE_LAT);
      col_first_s = sa_col0_first(ROWS, PE_LAT);
      t_nxt_s     = t_r + SA_CNT_W'(1'b1);
      row0_nxt_s  = (t_nxt_s < n_s);
      col0_nxt_s  = (t_nxt_s >= col_first_s) && (t_nxt_s < (col_first_s + n_s));
      skew_clr_s  = abort && (state_r != IDLE);
   end

   // Run sequencing FSM with all control outputs registered alongside the state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         cfg_r       <= {$bits(sa_cfg_t){1'b0}};
         k_r         <= {AW{1'b0}};
         t_r         <= {SA_CNT_W{1'b0}};
         row0_en_r   <= 1'b0;
         col0_val_r  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         load_weight <= 1'b0;
         w_rd_en     <= 1'b0;
         w_rd_addr   <= {AW{1'b0}};
         x_vec_idx   <= {VEC_W{1'b0}};
      end else if (skew_clr_s) begin
         // Abort: back to IDLE, every strobe low, no done; latched cfg is kept
         state_r     <= IDLE;
         k_r         <= {AW{1'b0}};
         t_r         <= {SA_CNT_W{1'b0}};
         row0_en_r   <= 1'b0;
         col0_val_r  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         load_weight <= 1'b0;
         w_rd_en     <= 1'b0;
         w_rd_addr   <= {AW{1'b0}};
         x_vec_idx   <= {VEC_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  cfg_r     <= cfg_in_s;
                  busy      <= 1'b1;
                  k_r       <= {AW{1'b0}};
                  t_r       <= {SA_CNT_W{1'b0}};
                  x_vec_idx <= {VEC_W{1'b0}};
                  if (!cfg_in_s.skip_weight) begin
                     // Farthest column's weight goes first
                     state_r     <= LOAD_W;
                     load_weight <= 1'b1;
                     w_rd_en     <= 1'b1;
                     w_rd_addr   <= AW'(COLS - 1);
                  end else if (cfg_in_s.num_vec != {SA_NV_W{1'b0}}) begin
                     state_r   <= COMPUTE;
                     row0_en_r <= 1'b1;
                  end else begin
                     state_r <= DONE;
                     done    <= 1'b1;
                  end
               end else begin
                  busy <= 1'b0;
               end
            end
            LOAD_W: begin
               if (cfg_r.skip_weight) begin
                  // Unreachable with a consistent cfg; recover quietly to IDLE
                  state_r     <= IDLE;
                  busy        <= 1'b0;
                  load_weight <= 1'b0;
                  w_rd_en     <= 1'b0;
                  w_rd_addr   <= {AW{1'b0}};
                  k_r         <= {AW{1'b0}};
               end else if (k_r == AW'(COLS - 1)) begin
                  load_weight <= 1'b0;
                  w_rd_en     <= 1'b0;
                  w_rd_addr   <= {AW{1'b0}};
                  k_r         <= {AW{1'b0}};
                  if (cfg_r.num_vec != {SA_NV_W{1'b0}}) begin
                     state_r   <= COMPUTE;
                     t_r       <= {SA_CNT_W{1'b0}};
                     row0_en_r <= 1'b1;
                     x_vec_idx <= {VEC_W{1'b0}};
                  end else begin
                     state_r <= DONE;
                     done    <= 1'b1;
                  end
               end else begin
                  k_r       <= k_r + AW'(1'b1);
                  w_rd_addr <= w_rd_addr - AW'(1'b1);
               end
            end
            COMPUTE: begin
               if (t_r == (len_s - SA_CNT_W'(1'b1))) begin
                  state_r    <= DONE;
                  done       <= 1'b1;
                  t_r        <= {SA_CNT_W{1'b0}};
                  row0_en_r  <= 1'b0;
                  col0_val_r <= 1'b0;
                  x_vec_idx  <= {VEC_W{1'b0}};
               end else begin
                  t_r        <= t_nxt_s;
                  row0_en_r  <= row0_nxt_s;
                  col0_val_r <= col0_nxt_s;
                  x_vec_idx  <= row0_nxt_s ? VEC_W'(t_nxt_s) : {VEC_W{1'b0}};
               end
            end
            DONE: begin
               state_r <= IDLE;
               done    <= 1'b0;
               busy    <= 1'b0;
            end
            default: begin
               state_r     <= IDLE;
               busy        <= 1'b0;
               done        <= 1'b0;
               load_weight <= 1'b0;
               w_rd_en     <= 1'b0;
               row0_en_r   <= 1'b0;
               col0_val_r  <= 1'b0;
            end
         endcase
      end
   end

   assign out_model = cfg_r.mode;
   assign Sx        = cfg_r.sx;
   assign Sy        = cfg_r.sy;

   sa_valid_skew #(.DEPTH(ROWS)) u_row_skew (
      .clk       (clk),
      .reset     (reset),
      .clr       (skew_clr_s),
      .valid_in  (row0_en_r),
      .valid_out (x_row_en)
   );

   sa_valid_skew #(.DEPTH(COLS)) u_col_skew (
      .clk       (clk),
      .reset     (reset),
      .clr       (skew_clr_s),
      .valid_in  (col0_val_r),
      .valid_out (out_col_valid)
   );

`ifdef SA_SEQ_CTRL_PERF_EN
   // Saturating busy-cycle and completed-run counters, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_busy_cyc <= 32'd0;
         perf_runs     <= 16'd0;
      end else begin
         if (busy && (perf_busy_cyc != {32{1'b1}})) begin
            perf_busy_cyc <= perf_busy_cyc + 32'd1;
         end else begin
            perf_busy_cyc <= perf_busy_cyc;
         end
         if (done && (perf_runs != {16{1'b1}})) begin
            perf_runs <= perf_runs + 16'd1;
         end else begin
            perf_runs <= perf_runs;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Self-checking bench for sa_seq_ctrl: directed test-plan scenarios plus a
// randomized run, all compared against a run-schedule reference model.
module tb_sa_seq_ctrl;

   localparam int ROWS   = 4;
   localparam int COLS   = 4;
   localparam int VEC_W  = 8;
   localparam int PE_LAT = 1;
   localparam int AW     = 2;

   logic clk = 1'b0;
   logic reset, start, abort, cfg_mode, cfg_sx, cfg_sy, cfg_skip_weight;
   logic [VEC_W-1:0] cfg_num_vec;
   logic busy, done, load_weight, out_model, Sx, Sy, w_rd_en;
   logic [AW-1:0] w_rd_addr;
   logic [ROWS-1:0] x_row_en;
   logic [VEC_W-1:0] x_vec_idx;
   logic [COLS-1:0] out_col_valid;
`ifdef SA_SEQ_CTRL_PERF_EN
   logic [31:0] perf_busy_cyc;
   logic [15:0] perf_runs;
`endif

   sa_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .VEC_W(VEC_W), .PE_LAT(PE_LAT)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .cfg_num_vec(cfg_num_vec), .cfg_mode(cfg_mode), .cfg_sx(cfg_sx), .cfg_sy(cfg_sy),
      .cfg_skip_weight(cfg_skip_weight), .busy(busy), .done(done),
      .load_weight(load_weight), .out_model(out_model), .Sx(Sx), .Sy(Sy),
      .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .x_row_en(x_row_en),
      .x_vec_idx(x_vec_idx), .out_col_valid(out_col_valid)
`ifdef SA_SEQ_CTRL_PERF_EN
      , .perf_busy_cyc(perf_busy_cyc), .perf_runs(perf_runs)
`endif
   );

   always #5 clk = ~clk;

   // Expected per-cycle strobes of the model
   typedef struct packed {
      logic            busy;
      logic            done;
      logic            lw;
      logic            wen;
      logic [AW-1:0]   waddr;
      logic [ROWS-1:0] xrow;
      logic [VEC_W-1:0] xidx;
      logic [COLS-1:0] colv;
   } exp_t;

   exp_t exp_cur = '0;
   exp_t q[$];
   logic m_mode = 1'b0, m_sx = 1'b0, m_sy = 1'b0;
   longint m_pbusy = 0, m_pruns = 0;
   int n_cmp = 0;
   int n_err = 0;

   function automatic logic [24:0] obs_vec();
      return {busy, done, load_weight, w_rd_en, w_rd_addr, x_row_en, x_vec_idx,
              out_col_valid, out_model, Sx, Sy};
   endfunction

   function automatic logic [24:0] exp_vec();
      return {exp_cur, m_mode, m_sx, m_sy};
   endfunction

   // Schedule a whole accepted run as a list of per-cycle expectations
   task automatic build_run(input int n, input logic sk);
      exp_t e;
      int len;
      if (!sk) begin
         for (int k = 0; k < COLS; k++) begin
            e = '0; e.busy = 1'b1; e.lw = 1'b1; e.wen = 1'b1; e.waddr = AW'(COLS - 1 - k);
            q.push_back(e);
         end
      end
      if (n != 0) begin
         len = n + ROWS + COLS - 2 + PE_LAT;
         for (int t = 0; t < len; t++) begin
            e = '0; e.busy = 1'b1;
            for (int r = 0; r < ROWS; r++) e.xrow[r] = (t >= r) && (t <= r + n - 1);
            e.xidx = (t < n) ? VEC_W'(t) : '0;
            for (int c = 0; c < COLS; c++)
               e.colv[c] = (t >= ROWS - 1 + c + PE_LAT) && (t <= ROWS - 2 + c + PE_LAT + n);
            q.push_back(e);
         end
      end
      e = '0; e.busy = 1'b1; e.done = 1'b1;
      q.push_back(e);
   endtask

   // Drive one cycle of inputs, clock it, advance the model, settle after the edge
   task automatic step(input logic st, input logic ab, input logic rs, input logic [VEC_W-1:0] nv,
                       input logic md, input logic x, input logic y, input logic sk);
      start = st; abort = ab; reset = rs; cfg_num_vec = nv;
      cfg_mode = md; cfg_sx = x; cfg_sy = y; cfg_skip_weight = sk;
      @(posedge clk);
      if (rs) begin
         exp_cur = '0; q.delete(); m_mode = 1'b0; m_sx = 1'b0; m_sy = 1'b0;
         m_pbusy = 0; m_pruns = 0;
      end else begin
         if (exp_cur.busy && m_pbusy < 64'hFFFF_FFFF) m_pbusy++;
         if (exp_cur.done && m_pruns < 64'hFFFF) m_pruns++;
         if (exp_cur.busy && ab) begin
            exp_cur = '0; q.delete();
         end else if (exp_cur.busy) begin
            if (q.size() > 0) exp_cur = q.pop_front();
            else exp_cur = '0;
         end else if (st) begin
            m_mode = md; m_sx = x; m_sy = y;
            build_run(int'(nv), sk);
            exp_cur = q.pop_front();
         end else begin
            exp_cur = '0;
         end
      end
      #1;
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, 1'b0, VEC_W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic test_reset();
      step(1'b0, 1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (obs_vec() !== 25'd0) begin
         n_err++; $display("FAIL reset_outputs got %h want %h", obs_vec(), 25'd0);
      end
      idle_step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
         n_err++; $display("FAIL reset_idle got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_basic();
      int done_at = -1, lw_cnt = 0, xr3_first = -1, cv3_first = -1;
      logic busy16 = 1'b1;
      logic [AW-1:0] addr2 = '0;
      step(1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int c = 1; c <= 17; c++) begin
         if (c > 1) idle_step();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL basic_cyc%0d got %h want %h", c, obs_vec(), exp_vec());
         end
         if (done === 1'b1 && done_at < 0) done_at = c;
         if (load_weight === 1'b1) lw_cnt++;
         if (c == 2) addr2 = w_rd_addr;
         if (c == 16) busy16 = busy;
         if (x_row_en[3] === 1'b1 && xr3_first < 0) xr3_first = c;
         if (out_col_valid[3] === 1'b1 && cv3_first < 0) cv3_first = c;
      end
      n_cmp++; if (done_at != 15) begin n_err++; $display("FAIL basic_done_cycle got %0d want 15", done_at); end
      n_cmp++; if (lw_cnt != 4) begin n_err++; $display("FAIL basic_lw_cycles got %0d want 4", lw_cnt); end
      n_cmp++; if (addr2 !== 2'd2) begin n_err++; $display("FAIL basic_addr_cyc2 got %0d want 2", addr2); end
      n_cmp++; if (busy16 !== 1'b0) begin n_err++; $display("FAIL basic_busy16 got %b want 0", busy16); end
      n_cmp++; if (xr3_first != 8) begin n_err++; $display("FAIL basic_xrow3_first got %0d want 8", xr3_first); end
      n_cmp++; if (cv3_first != 12) begin n_err++; $display("FAIL basic_colv3_first got %0d want 12", cv3_first); end
   endtask

   task automatic test_skip();
      int done_at = -1, lw_cnt = 0;
      step(1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) idle_step();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL skip_cyc%0d got %h want %h", c, obs_vec(), exp_vec());
         end
         if (done === 1'b1 && done_at < 0) done_at = c;
         if (load_weight === 1'b1) lw_cnt++;
      end
      n_cmp++; if (done_at != 11) begin n_err++; $display("FAIL skip_done_cycle got %0d want 11", done_at); end
      n_cmp++; if (lw_cnt != 0) begin n_err++; $display("FAIL skip_lw_cycles got %0d want 0", lw_cnt); end
      n_cmp++;
      if ({out_model, Sx, Sy} !== 3'b110) begin
         n_err++; $display("FAIL skip_cfg_hold got %b want 110", {out_model, Sx, Sy});
      end
   endtask

   task automatic test_zero_vec();
      int done_at = -1, strobes = 0;
      step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 6; c++) begin
         if (c > 1) idle_step();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL zero_cyc%0d got %h want %h", c, obs_vec(), exp_vec());
         end
         if (done === 1'b1 && done_at < 0) done_at = c;
         if (x_row_en !== '0 || out_col_valid !== '0) strobes++;
      end
      n_cmp++; if (done_at != 5) begin n_err++; $display("FAIL zero_done_cycle got %0d want 5", done_at); end
      n_cmp++; if (strobes != 0) begin n_err++; $display("FAIL zero_strobes got %0d want 0", strobes); end
   endtask

   task automatic test_abort();
      step(1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int c = 2; c <= 7; c++) idle_step();
      step(1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({busy, done, load_weight, w_rd_en, x_row_en, out_col_valid} !== 12'd0) begin
         n_err++; $display("FAIL abort_strobes got %h want 0",
                           {busy, done, load_weight, w_rd_en, x_row_en, out_col_valid});
      end
      idle_step();
      step(1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if ({busy, load_weight} !== 2'b11) begin
         n_err++; $display("FAIL abort_restart got %b want 11", {busy, load_weight});
      end
      for (int c = 0; c < 20; c++) begin
         idle_step();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL abort_run%0d got %h want %h", c, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_back_to_back();
      int dones = 0, idles = 0, bad_idle = 0;
      logic prev_done = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         step(1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b1, 1'b1, 1'b1);
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL b2b_cyc%0d got %h want %h", c, obs_vec(), exp_vec());
         end
         if (done === 1'b1) dones++;
         if (busy === 1'b0) begin
            idles++;
            if (!prev_done) bad_idle++;
         end
         prev_done = done;
      end
      n_cmp++; if (dones != 4) begin n_err++; $display("FAIL b2b_done_count got %0d want 4", dones); end
      n_cmp++; if (idles != 4) begin n_err++; $display("FAIL b2b_idle_count got %0d want 4", idles); end
      n_cmp++; if (bad_idle != 0) begin n_err++; $display("FAIL b2b_idle_not_after_done got %0d want 0", bad_idle); end
      for (int c = 0; c < 12; c++) idle_step();
   endtask

   task automatic test_reset_mid_run();
      step(1'b1, 1'b0, 1'b0, 8'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int c = 2; c <= 7; c++) idle_step();
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before got %b want 1", busy); end
      step(1'b1, 1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (obs_vec() !== 25'd0) begin
         n_err++; $display("FAIL midrst_outputs got %h want 0", obs_vec());
      end
`ifdef SA_SEQ_CTRL_PERF_EN
      n_cmp++;
      if ({perf_busy_cyc, perf_runs} !== 48'd0) begin
         n_err++; $display("FAIL midrst_perf got %h want 0", {perf_busy_cyc, perf_runs});
      end
`endif
   endtask

   task automatic test_random();
      logic st, ab, rs;
      logic [VEC_W-1:0] nv;
      for (int c = 0; c < 3000; c++) begin
         st = ($urandom_range(0, 2) == 0);
         ab = ($urandom_range(0, 39) == 0);
         rs = ($urandom_range(0, 299) == 0);
         nv = ($urandom_range(0, 9) == 0) ? VEC_W'($urandom_range(0, 40)) : VEC_W'($urandom_range(0, 6));
         step(st, ab, rs, nv, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL rand_cyc%0d got %h want %h", c, obs_vec(), exp_vec());
         end
`ifdef SA_SEQ_CTRL_PERF_EN
         n_cmp++;
         if (perf_busy_cyc !== 32'(m_pbusy) || perf_runs !== 16'(m_pruns)) begin
            n_err++; $display("FAIL rand_perf%0d got %0d/%0d want %0d/%0d", c,
                              perf_busy_cyc, perf_runs, m_pbusy, m_pruns);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_skip();
      test_zero_vec();
      test_abort();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
